// File: rtl/datapath_readreg.sv
// ---------------------------------------------------------------------------
// datapath_readreg
//
// Sequential binary-to-BCD reader for the datapath load register. A start
// request samples the parallel value D, then runs one shift-and-add-3
// (double-dabble) step per clock for WIDTH clocks. The packed BCD result is
// published on bcd together with a one-cycle done pulse. The result then
// stays stable until the next conversion completes.
//
// Parameters
//   WIDTH  : binary input width, which is also the number of conversion steps
//   DIGITS : number of BCD output digits (10^DIGITS must exceed 2^WIDTH-1)
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   start : conversion request, acted on only when no conversion is running
//   D     : binary value, captured on the accepting edge
//   bcd   : packed BCD result, digit 0 (ones) in bcd[3:0]
//   busy  : high while converting and during the done cycle
//   done  : one-cycle pulse, bcd has just been updated
// ---------------------------------------------------------------------------
module datapath_readreg #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      D,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     bin_q;
    logic [SW-1:0]        scratch;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        adjusted;
    logic [SW+WIDTH-1:0]  shifted;
    logic                 accept;
    logic                 last_step;

    // One double-dabble step: every nibble of 5 or more gets +3 (no carry
    // between nibbles, a nibble never exceeds 9 so the sum stays below 13),
    // then the combined {scratch, binary} vector shifts left by one so the
    // binary MSB enters scratch bit 0.
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end else begin
                adjusted[4*i +: 4] = scratch[4*i +: 4];
            end
        end
        shifted = {adjusted, bin_q} << 1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The edge that leaves DONE also serves as an
    // accepting edge, so a continuously held start restarts every WIDTH+1
    // cycles and each result still gets its own done pulse. A start pulse
    // that falls entirely inside CONVERT is simply dropped.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt == LAST_STEP) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CONVERT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. bcd is loaded only on the final step,
    // so it holds the previous result for the whole of the next conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (accept) begin
                bin_q   <= D;
                scratch <= '0;
                cnt     <= '0;
            end else if (state == CONVERT) begin
                scratch <= shifted[SW+WIDTH-1:WIDTH];
                bin_q   <= shifted[WIDTH-1:0];
                cnt     <= cnt + 1'b1;
            end
            if (last_step) begin
                bcd <= shifted[SW+WIDTH-1:WIDTH];
            end
            done <= last_step;
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_datapath_readreg.sv
// ---------------------------------------------------------------------------
// tb_datapath_readreg
//
// Self-checking bench for datapath_readreg at the default 10-bit / 4-digit
// configuration. Expected BCD values come from a decimal model that splits
// the value into digits with / and %.
// ---------------------------------------------------------------------------
module tb_datapath_readreg;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  D     = '0;
    logic [15:0] bcd;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [15:0] prev_bcd    = '0;
    int          stable_errs = 0;

    datapath_readreg #(
        .WIDTH (10),
        .DIGITS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .D    (D),
        .bcd  (bcd),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Watches bcd: outside reset it may only change in a cycle where done is high.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bcd = 16'h0000;
        end else begin
            if (bcd !== prev_bcd && done !== 1'b1) begin
                stable_errs++;
            end
            prev_bcd = bcd;
        end
    end

    // Decimal reference: digit i is (v / 10^i) % 10.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drives a one-cycle start with value v, then scrambles D. Reports the
    // sample index (relative to the accepting edge) of the done pulse, the
    // bcd seen there, busy cycles and the number of done pulses.
    task automatic applyStimulus(input logic [9:0] v, output logic [15:0] res,
                                 output int lat, output int bcnt, output int dcnt);
        res  = 'x;
        lat  = -1;
        bcnt = 0;
        dcnt = 0;
        @(negedge clk);
        D     = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        D     = 10'($urandom);
        for (int k = 0; k < 30; k++) begin
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                dcnt++;
                lat = k;
                res = bcd;
            end
            if (busy !== 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (bcd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_bcd: got %h expected %h", bcd, 16'h0000);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        logic [15:0] res;
        int lat, bcnt, dcnt;
        applyStimulus(10'd0, res, lat, bcnt, dcnt);
        total++;
        if (lat !== 10) begin
            bad++;
            $display("[TB] FAIL zero_latency: got %0d expected 10", lat);
        end
        total++;
        if (res !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL zero_bcd: got %h expected 0000", res);
        end
        total++;
        if (bcnt !== 11) begin
            bad++;
            $display("[TB] FAIL zero_busy_cycles: got %0d expected 11", bcnt);
        end
        total++;
        if (dcnt !== 1) begin
            bad++;
            $display("[TB] FAIL zero_done_pulses: got %0d expected 1", dcnt);
        end
    endtask

    task automatic test_full_scale();
        int vals[4] = '{1023, 999, 512, 10};
        logic [15:0] res;
        int lat, bcnt, dcnt;
        foreach (vals[i]) begin
            applyStimulus(10'(vals[i]), res, lat, bcnt, dcnt);
            total++;
            if (res !== ref_bcd(vals[i]) || lat !== 10) begin
                bad++;
                $display("[TB] FAIL full_scale_%0d: got bcd=%h lat=%0d expected bcd=%h lat=10",
                         vals[i], res, lat, ref_bcd(vals[i]));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int          dcnt = 0;
        int          dk   = -1;
        logic [15:0] res  = 'x;
        @(negedge clk);
        D     = 10'd345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        D     = 10'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 4; k < 30; k++) begin
            if (done === 1'b1) begin
                dcnt++;
                dk  = k;
                res = bcd;
            end
            @(negedge clk);
        end
        total++;
        if (dcnt !== 1) begin
            bad++;
            $display("[TB] FAIL busy_start_pulses: got %0d expected 1", dcnt);
        end
        total++;
        if (res !== 16'h0345 || dk !== 10) begin
            bad++;
            $display("[TB] FAIL busy_start_result: got bcd=%h at %0d expected 0345 at 10", res, dk);
        end
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        int bcnt = 0;
        @(negedge clk);
        D     = 10'd600;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        total++;
        if (bcd !== 16'h0345) begin
            bad++;
            $display("[TB] FAIL hold_before_reset: got %h expected 0345", bcd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_async: got bcd=%h busy=%b done=%b expected 0000 0 0",
                     bcd, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
            if (busy === 1'b1) bcnt++;
        end
        total++;
        if (dcnt !== 0 || bcnt !== 0 || bcd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_mid_quiet: got done=%0d busy=%0d bcd=%h expected 0 0 0000",
                     dcnt, bcnt, bcd);
        end
    endtask

    task automatic test_back_to_back();
        int          n        = 0;
        int          t[2]     = '{-1, -1};
        logic [15:0] r[2]     = '{16'hxxxx, 16'hxxxx};
        int          hold_bad = 0;
        @(negedge clk);
        D     = 10'd123;
        start = 1'b1;
        @(negedge clk);
        D     = 10'd456;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                t[n] = k;
                r[n] = bcd;
                n++;
                if (n == 2) begin
                    start = 1'b0;
                    break;
                end
            end else if (n == 1 && bcd !== 16'h0123) begin
                hold_bad++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) @(negedge clk);
        total++;
        if (r[0] !== 16'h0123) begin
            bad++;
            $display("[TB] FAIL b2b_first: got %h expected 0123", r[0]);
        end
        total++;
        if (r[1] !== 16'h0456) begin
            bad++;
            $display("[TB] FAIL b2b_second: got %h expected 0456", r[1]);
        end
        total++;
        if (t[0] !== 10 || t[1] - t[0] !== 11) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: got first=%0d gap=%0d expected 10 11", t[0], t[1] - t[0]);
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_hold: got %0d bad samples expected 0", hold_bad);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] res;
        int lat, bcnt, dcnt, v;
        for (int i = 0; i < 1024 + 64; i++) begin
            v = (i < 1024) ? i : int'($urandom_range(0, 1023));
            applyStimulus(10'(v), res, lat, bcnt, dcnt);
            total++;
            if (res !== ref_bcd(v) || lat !== 10 || dcnt !== 1) begin
                bad++;
                $display("[TB] FAIL sweep_%0d: got bcd=%h lat=%0d pulses=%0d expected bcd=%h lat=10 pulses=1",
                         v, res, lat, dcnt, ref_bcd(v));
            end
        end
        total++;
        if (stable_errs !== 0) begin
            bad++;
            $display("[TB] FAIL bcd_stability: got %0d changes outside done expected 0", stable_errs);
        end
    endtask

    initial begin
        $display("[TB] starting datapath_readreg bench");
        test_reset();
        test_zero();
        test_full_scale();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
